// File: rtl/rf_pkg.sv
// Shared widths, controller state type and small helpers for the reg_file write-port logic.
package rf_pkg;

  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NREGS    = 32;
  localparam int unsigned RF_STARVE_W = 4;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_ctrl_state_t;

  // x0 is architecturally zero, so writes and pending bits for it are suppressed.
  function automatic logic rf_addr_nz(input logic [RF_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/reg_file_wb_ctrl_scoreboard.sv
// rf_scoreboard: pending-write bit per register (x0 hard zero), set beats clear, two query ports.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set_en,
  input  logic [RF_ADDR_W-1:0] i_set_addr,
  input  logic                 i_clr_en,
  input  logic [RF_ADDR_W-1:0] i_clr_addr,
  input  logic [RF_ADDR_W-1:0] i_q1_addr,
  input  logic [RF_ADDR_W-1:0] i_q2_addr,
  output logic                 o_q1_busy,
  output logic                 o_q2_busy
);

  logic [RF_NREGS-1:0] r_pending;
  logic [RF_NREGS-1:0] w_pending_nxt;

  // Clear first so a same-cycle set to the same register survives.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en) w_pending_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_pending_nxt[i_set_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  assign o_q1_busy = r_pending[i_q1_addr];
  assign o_q2_busy = r_pending[i_q2_addr];

endmodule

// File: rtl/reg_file_wb_ctrl.sv
// Write-port controller for reg_file: pipeline/multi-cycle arbitration with starvation guard,
// pending-write scoreboard, and an optional post-reset zero sweep (REGFILE_INIT_SWEEP_EN).
module reg_file_wb_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p_valid,
  output logic                 p_ready,
  input  logic [RF_ADDR_W-1:0] p_addr,
  input  logic [RF_DATA_W-1:0] p_data,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [RF_ADDR_W-1:0] m_addr,
  input  logic [RF_DATA_W-1:0] m_data,
  input  logic                 issue_valid,
  input  logic [RF_ADDR_W-1:0] issue_addr,
  input  logic [RF_ADDR_W-1:0] q1_addr,
  input  logic [RF_ADDR_W-1:0] q2_addr,
  output logic                 q1_busy,
  output logic                 q2_busy,
  output logic                 we,
  output logic [RF_ADDR_W-1:0] wa,
  output logic [RF_DATA_W-1:0] wd,
  output logic                 init_done
);

  localparam logic [RF_STARVE_W-1:0] STARVE_MAX = RF_STARVE_W'(STARVE_LIMIT);
`ifdef REGFILE_INIT_SWEEP_EN
  localparam rf_ctrl_state_t         RST_STATE  = RF_INIT;
  localparam logic [RF_ADDR_W-1:0]   IDX_FIRST  = RF_ADDR_W'(1);
  localparam logic [RF_ADDR_W-1:0]   IDX_LAST   = RF_ADDR_W'(RF_NREGS - 1);
`else
  localparam rf_ctrl_state_t         RST_STATE  = RF_RUN;
`endif

  rf_ctrl_state_t             r_state, w_state_nxt;
  logic [RF_STARVE_W-1:0]     r_starve, w_starve_nxt;
  logic                       r_we, w_we_nxt;
  logic [RF_ADDR_W-1:0]       r_wa, w_wa_nxt;
  logic [RF_DATA_W-1:0]       r_wd, w_wd_nxt;
  logic                       r_init_done, w_init_done_nxt;
`ifdef REGFILE_INIT_SWEEP_EN
  logic [RF_ADDR_W-1:0]       r_idx, w_idx_nxt;
`endif

  logic w_force_m;
  logic w_p_hs;
  logic w_m_hs;

  // Ports open only once init_done is up, which also keeps readies low through reset.
  assign w_force_m = (r_starve == STARVE_MAX);
  assign p_ready   = r_init_done && !(m_valid && w_force_m);
  assign m_ready   = r_init_done && (!p_valid || w_force_m);
  assign w_p_hs    = p_valid && p_ready;
  assign w_m_hs    = m_valid && m_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_starve_nxt    = r_starve;
    w_we_nxt        = 1'b0;
    w_wa_nxt        = r_wa;
    w_wd_nxt        = r_wd;
    w_init_done_nxt = r_init_done;
`ifdef REGFILE_INIT_SWEEP_EN
    w_idx_nxt       = r_idx;
`endif

    if (!m_valid || w_m_hs)  w_starve_nxt = '0;
    else if (!w_force_m)     w_starve_nxt = r_starve + RF_STARVE_W'(1);

    case (r_state)
      RF_INIT: begin
`ifdef REGFILE_INIT_SWEEP_EN
        w_we_nxt  = 1'b1;
        w_wa_nxt  = r_idx;
        w_wd_nxt  = '0;
        w_idx_nxt = r_idx + RF_ADDR_W'(1);
        if (r_idx == IDX_LAST) w_state_nxt = RF_RUN;
`else
        w_state_nxt = RF_RUN;
`endif
      end
      RF_RUN: begin
        w_init_done_nxt = 1'b1;
        // Arbitration guarantees at most one handshake per cycle.
        if (w_m_hs && rf_addr_nz(m_addr)) begin
          w_we_nxt = 1'b1;
          w_wa_nxt = m_addr;
          w_wd_nxt = m_data;
        end else if (w_p_hs && rf_addr_nz(p_addr)) begin
          w_we_nxt = 1'b1;
          w_wa_nxt = p_addr;
          w_wd_nxt = p_data;
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_starve    <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_init_done <= 1'b0;
`ifdef REGFILE_INIT_SWEEP_EN
      r_idx       <= IDX_FIRST;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_starve    <= w_starve_nxt;
      r_we        <= w_we_nxt;
      r_wa        <= w_wa_nxt;
      r_wd        <= w_wd_nxt;
      r_init_done <= w_init_done_nxt;
`ifdef REGFILE_INIT_SWEEP_EN
      r_idx       <= w_idx_nxt;
`endif
    end
  end

  assign we        = r_we;
  assign wa        = r_wa;
  assign wd        = r_wd;
  assign init_done = r_init_done;

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (issue_valid && rf_addr_nz(issue_addr)),
    .i_set_addr (issue_addr),
    .i_clr_en   (w_m_hs),
    .i_clr_addr (m_addr),
    .i_q1_addr  (q1_addr),
    .i_q2_addr  (q2_addr),
    .o_q1_busy  (q1_busy),
    .o_q2_busy  (q2_busy)
  );

endmodule

// File: doc/reg_file_wb_ctrl.md
# reg_file_wb_ctrl

Write-port controller for the 32×32 `reg_file`, which has a single write port (`we`/`wa`/`wd`). It arbitrates that port between the in-order pipeline writeback and the multi-cycle unit (loads, divider), with a starvation guard. After reset it sequences a zero-initialisation sweep of x1..x31. It also keeps a pending-write scoreboard that hazard logic queries to stall on in-flight multi-cycle results.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: cycles the multi-cycle port may wait while valid before it is forced a grant; legal range 1..15.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `p_valid` input 1: pipeline writeback request.
- `p_ready` output 1: pipeline request accepted this cycle.
- `p_addr` input 5: pipeline destination register.
- `p_data` input 32: pipeline write data.
- `m_valid` input 1: multi-cycle unit writeback request.
- `m_ready` output 1: multi-cycle request accepted this cycle.
- `m_addr` input 5: multi-cycle destination register.
- `m_data` input 32: multi-cycle write data.
- `issue_valid` input 1: a multi-cycle op targeting `issue_addr` was issued.
- `issue_addr` input 5: destination register of the issued op.
- `q1_addr`, `q2_addr` input 5 each: scoreboard query addresses (rs1, rs2).
- `q1_busy`, `q2_busy` output 1 each: a write is pending for the queried register (combinational from the scoreboard register).
- `we` output 1: to `reg_file.we`.
- `wa` output 5: to `reg_file.wa`.
- `wd` output 32: to `reg_file.wd`.
- `init_done` output 1: high once the init sweep has finished.

## Operation
- States: INIT → RUN. INIT only when `REGFILE_INIT_SWEEP_EN` is defined; otherwise reset goes straight to RUN.
- INIT:
  - Counter `idx` steps 1..31; each cycle issues a write of 0 to `idx`. x0 is never written.
  - `p_ready = m_ready = 0` throughout.
  - After the write of idx=31, the next state is RUN and `init_done` goes to 1.
- RUN arbitration:
  - `force_m = (starve_cnt == STARVE_LIMIT)`.
  - `p_ready = !(m_valid && force_m)`.
  - `m_ready = !p_valid || force_m`.
  - A handshake completes on `valid && ready`. At most one completes per cycle.
  - With both ports idle, both readies are high.
- Starvation counter:
  - Increments when `m_valid && !m_ready`.
  - Clears on an m handshake or when `m_valid` is low.
  - Saturates at `STARVE_LIMIT`.
- Write issue:
  - An accepted request with addr ≠ 0 registers `we=1`, `wa=addr`, `wd=data` for the next cycle.
  - An accepted request with addr = 0 completes the handshake but leaves `we=0`.
  - With no accepted request, `we=0`; `wa`/`wd` hold their previous values.
- Scoreboard (`pending[31:1]`, x0 hard 0):
  - `issue_valid` with addr ≠ 0 sets `pending[issue_addr]`.
  - An accepted m handshake clears `pending[m_addr]`.
  - Set and clear to the same address in the same cycle: set wins.
  - p handshakes never touch the scoreboard.
  - `issue_valid` is honoured in INIT too.
- Reset mid-operation (`rst_n` low in any state):
  - Next edge: state = INIT (or RUN when the sweep is compiled out), `idx=1`, `starve_cnt=0`, `pending=0`.
  - Any in-flight accepted write is dropped, never presented on `we`.

## Timing
- Reset values: `we=0`, `wa=0`, `wd=0`, `init_done=0`, `p_ready=0`, `m_ready=0`, `q1_busy=0`, `q2_busy=0`.
- Handshake at edge N → `we`/`wa`/`wd` valid during cycle N+1 → `reg_file` commits at edge N+2. Read-after-write forwarding is the pipeline's responsibility.
- Init sweep: 31 consecutive `we` cycles starting the cycle after `rst_n` is seen high; `init_done` rises one cycle after the last one. RUN is reached 32 cycles after reset release.
- Scoreboard updates at the handshake/issue edge; `qN_busy` reflects them one cycle later.
- Sustained contention with both ports valid: m is granted once every `STARVE_LIMIT+1` cycles.

## Configuration
- `REGFILE_INIT_SWEEP_EN`:
  - Defined: INIT state, `idx` counter and zero sweep are present.
  - Undefined: no sweep logic; RUN from reset; `init_done=0` while `rst_n` is low, 1 from the first cycle after release; register contents are undefined until written.

## Structure
- Shared package `rf_pkg`: `RF_ADDR_W=5`, `RF_DATA_W=32`, `RF_NREGS=32`, and state enum `rf_ctrl_state_t {RF_INIT, RF_RUN}`.
- One sub-module, `rf_scoreboard`: the pending bit-vector with set/clear priority and the two query ports.
- Arbitration, starvation counter, init FSM and output registers live in the top level.

## Test plan
- Init sweep (macro defined): release reset, idle inputs. Required: `we=1` for 31 cycles with `wa` = 1..31 and `wd=0`; `init_done` rises one cycle after; both readies high thereafter. Reading `reg_file` x5 returns 00000000.
- Contention: `p_valid=1` continuously with `p_addr=3`, `p_data=0x03030303`; `m_valid=1` with `m_addr=7`, `m_data=0x07070707`; `STARVE_LIMIT=4`. Required: 4 p writes, then one write to x7; pattern repeats every 5 cycles.
- x0 write: accepted p request to x0 with data FFFFFFFF. Required: `p_ready=1`, `we` stays 0, `reg_file` x0 reads 0.
- Scoreboard: `issue_valid` to x9, then m writeback to x9 four cycles later. Required: `q1_addr=9` gives `q1_busy=1` from the cycle after issue until the cycle after the m handshake, then 0.
- Same-cycle set/clear: issue to x12 in the same cycle as the m handshake to x12. Required: `q2_busy` for x12 remains 1.
- Reset mid-operation: assert `rst_n=0` during init at `idx=10`, then release. Required: outputs return to reset values; sweep restarts at `wa=1`; `pending` is all zeros.
